// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for the multicycle MIPS datapath
module multicycle_control (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       ula_src_a,
  output logic [1:0] ula_src_b,
  output logic       zero_ext,
  output logic [2:0] ula_operation,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
    R_EXEC, R_WB, BRANCH, JUMP, I_EXEC, I_WB
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
    OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_ANDI = 6'b001100,
    OP_ORI = 6'b001101, OP_XORI = 6'b001110, OP_LUI = 6'b001111, OP_LW = 6'b100011,
    OP_SW = 6'b101011;
  state_t state_q, state_d;
  logic is_mem, is_br, is_i, is_logic;
  assign is_mem   = opcode inside {OP_LW, OP_SW};
  assign is_br    = opcode inside {OP_BEQ, OP_BNE};
  assign is_i     = opcode inside {OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
  assign is_logic = opcode inside {OP_ANDI, OP_ORI, OP_XORI};
  assign state    = state_q;
  // next-state selection; memory states hold until the access completes
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:     state_d = mem_ready ? DECODE : FETCH;
      DECODE:    state_d = is_mem ? MEM_ADDR : opcode == OP_R ? R_EXEC : is_br ? BRANCH :
                           opcode == OP_J ? JUMP : is_i ? I_EXEC : FETCH;
      MEM_ADDR:  state_d = opcode == OP_LW ? MEM_READ : MEM_WRITE;
      MEM_READ:  state_d = mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: state_d = mem_ready ? FETCH : MEM_WRITE;
      R_EXEC:    state_d = R_WB;
      I_EXEC:    state_d = I_WB;
      default:   state_d = FETCH;
    endcase
  end
  // state register, forced back to FETCH the moment reset asserts
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state_q <= FETCH;
    else state_q <= state_d;
  // Moore decode of the datapath controls, all held low while in reset
  always_comb begin
    pc_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    ula_src_a     = 1'b0;
    ula_src_b     = 2'b00;
    zero_ext      = 1'b0;
    ula_operation = 3'b000;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    if (reset_n)
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          ula_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: begin
          ula_src_b  = 2'b11;
          illegal_op = ~(is_mem | is_br | is_i | opcode == OP_R | opcode == OP_J);
        end
        MEM_ADDR: begin
          ula_src_a = 1'b1;
          ula_src_b = 2'b10;
        end
        MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        R_EXEC: begin
          ula_src_a     = 1'b1;
          ula_operation = 3'b010;
        end
        R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        BRANCH: begin
          ula_src_a     = 1'b1;
          ula_operation = 3'b001;
          pc_source     = 2'b01;
          pc_write      = opcode == OP_BEQ ? zero : ~zero;
        end
        JUMP: begin
          pc_source = 2'b10;
          pc_write  = 1'b1;
        end
        I_EXEC: begin
          ula_src_a     = 1'b1;
          ula_src_b     = 2'b10;
          zero_ext      = is_logic;
          ula_operation = opcode == OP_SLTI ? 3'b011 : opcode == OP_ANDI ? 3'b100 :
                          opcode == OP_ORI ? 3'b101 : opcode == OP_XORI ? 3'b110 :
                          opcode == OP_LUI ? 3'b111 : 3'b000;
        end
        I_WB: reg_write = 1'b1;
        default: ;
      endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: per-instruction cycle trace model against the control FSM
module tb_multicycle_control;
  logic       clock = 1'b0, reset_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       ula_src_a, zero_ext, illegal_op;
  logic [1:0] ula_src_b, pc_source;
  logic [2:0] ula_operation;
  logic [3:0] state;
  int tests = 0, fails = 0;

  multicycle_control dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .ula_src_a(ula_src_a), .ula_src_b(ula_src_b), .zero_ext(zero_ext),
    .ula_operation(ula_operation), .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
  );

  always #5 clock = ~clock;

  // packed order: pcw iord mr mw irw rdst m2r rw sa sb[2] zx op[3] ps[2] ill
  function automatic logic [17:0] mk(input logic pcw, iord, mr, mw, irw, rdst, m2r, rw, sa,
                                     input logic [1:0] sb, input logic zx,
                                     input logic [2:0] op, input logic [1:0] ps, input logic ill);
    return {pcw, iord, mr, mw, irw, rdst, m2r, rw, sa, sb, zx, op, ps, ill};
  endfunction

  function automatic logic [17:0] outs();
    return {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
            ula_src_a, ula_src_b, zero_ext, ula_operation, pc_source, illegal_op};
  endfunction

  task automatic chk(input string tag, input logic [3:0] st, input logic [17:0] o);
    tests += 2;
    assert (state === st) else begin
      fails++;
      $error("FAIL %s state got %0d want %0d", tag, state, st);
    end
    assert (outs() === o) else begin
      fails++;
      $error("FAIL %s outputs got %b want %b (state %0d)", tag, outs(), o, st);
    end
  endtask

  // one cycle: drive inputs after the falling edge, check, move to next falling edge
  task automatic cyc(input string tag, input logic [3:0] st, input logic [17:0] o,
                     input logic rdy, input logic z);
    mem_ready = rdy;
    zero = z;
    #1;
    chk(tag, st, o);
    @(negedge clock);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // expected trace of a whole instruction, built from its class
  task automatic run(input string tag, input logic [5:0] op, input logic z,
                     input int wf, input int wm);
    logic [2:0] iop;
    logic legal;
    opcode = op;
    for (int i = 0; i < wf; i++) cyc(tag, 4'd0, mk(0,0,1,0,0,0,0,0,0,2'b01,0,3'd0,2'b00,0), 1'b0, rb());
    cyc(tag, 4'd0, mk(1,0,1,0,1,0,0,0,0,2'b01,0,3'd0,2'b00,0), 1'b1, rb());
    legal = op inside {6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15, 6'd35, 6'd43};
    cyc(tag, 4'd1, mk(0,0,0,0,0,0,0,0,0,2'b11,0,3'd0,2'b00,!legal), rb(), rb());
    if (!legal) return;
    if (op == 6'd35 || op == 6'd43) begin
      cyc(tag, 4'd2, mk(0,0,0,0,0,0,0,0,1,2'b10,0,3'd0,2'b00,0), rb(), rb());
      if (op == 6'd35) begin
        for (int i = 0; i <= wm; i++) cyc(tag, 4'd3, mk(0,1,1,0,0,0,0,0,0,2'b00,0,3'd0,2'b00,0), i == wm, rb());
        cyc(tag, 4'd4, mk(0,0,0,0,0,0,1,1,0,2'b00,0,3'd0,2'b00,0), rb(), rb());
      end else
        for (int i = 0; i <= wm; i++) cyc(tag, 4'd5, mk(0,1,0,1,0,0,0,0,0,2'b00,0,3'd0,2'b00,0), i == wm, rb());
    end else if (op == 6'd0) begin
      cyc(tag, 4'd6, mk(0,0,0,0,0,0,0,0,1,2'b00,0,3'd2,2'b00,0), rb(), rb());
      cyc(tag, 4'd7, mk(0,0,0,0,0,1,0,1,0,2'b00,0,3'd0,2'b00,0), rb(), rb());
    end else if (op == 6'd4 || op == 6'd5) begin
      cyc(tag, 4'd8, mk((op == 6'd4) == z,0,0,0,0,0,0,0,1,2'b00,0,3'd1,2'b01,0), rb(), z);
    end else if (op == 6'd2) begin
      cyc(tag, 4'd9, mk(1,0,0,0,0,0,0,0,0,2'b00,0,3'd0,2'b10,0), rb(), rb());
    end else begin
      iop = op == 6'd8 ? 3'd0 : op == 6'd10 ? 3'd3 : 3'(op - 6'd8);
      cyc(tag, 4'd10, mk(0,0,0,0,0,0,0,0,1,2'b10,op inside {6'd12, 6'd13, 6'd14},iop,2'b00,0), rb(), rb());
      cyc(tag, 4'd11, mk(0,0,0,0,0,0,0,1,0,2'b00,0,3'd0,2'b00,0), rb(), rb());
    end
  endtask

  logic [5:0] ops [13] = '{6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd10, 6'd12, 6'd13, 6'd14,
                           6'd15, 6'd35, 6'd43, 6'd63};

  initial begin
    mem_ready = 1'b1;
    #1;
    chk("reset_init", 4'd0, 18'd0);
    @(negedge clock);
    chk("reset_held_edge", 4'd0, 18'd0);
    reset_n = 1'b1;
    run("lw", 6'b100011, 1'b0, 0, 0);
    run("sw_wait3", 6'b101011, 1'b0, 0, 3);
    run("beq_z1", 6'b000100, 1'b1, 0, 0);
    run("beq_z0", 6'b000100, 1'b0, 0, 0);
    run("bne_z1", 6'b000101, 1'b1, 0, 0);
    run("bne_z0", 6'b000101, 1'b0, 0, 0);
    run("andi", 6'b001100, 1'b0, 0, 0);
    run("slti", 6'b001010, 1'b0, 0, 0);
    run("illegal", 6'b111111, 1'b0, 0, 0);
    run("r_type", 6'b000000, 1'b0, 1, 0);
    run("jump", 6'b000010, 1'b0, 0, 0);
    run("lui", 6'b001111, 1'b0, 0, 0);
    // reset in the middle of a load while mem_read is high
    opcode = 6'b100011;
    cyc("rst_mid", 4'd0, mk(1,0,1,0,1,0,0,0,0,2'b01,0,3'd0,2'b00,0), 1'b1, 1'b0);
    cyc("rst_mid", 4'd1, mk(0,0,0,0,0,0,0,0,0,2'b11,0,3'd0,2'b00,0), 1'b0, 1'b0);
    cyc("rst_mid", 4'd2, mk(0,0,0,0,0,0,0,0,1,2'b10,0,3'd0,2'b00,0), 1'b0, 1'b0);
    mem_ready = 1'b0;
    #1;
    chk("rst_pre", 4'd3, mk(0,1,1,0,0,0,0,0,0,2'b00,0,3'd0,2'b00,0));
    reset_n = 1'b0;
    #1;
    chk("rst_async", 4'd0, 18'd0);
    mem_ready = 1'b1;
    @(negedge clock);
    chk("rst_hold", 4'd0, 18'd0);
    reset_n = 1'b1;
    run("after_rst", 6'b000000, 1'b0, 0, 0);
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 12)];
      run("rand", op, rb(), $urandom_range(0, 2), $urandom_range(0, 3));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
